// File: rtl/restoring_divider_16bit_pkg.sv
// Shared types and constants for the restoring divider slice.
// Width, state encoding and the divide-by-zero quotient pattern live here.
package divider_pkg_haleyorr2027;

  localparam int DIV_WIDTH = 16;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);
  localparam logic [DIV_WIDTH-1:0] DIV_Q_DIVZERO = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/restoring_divider_16bit_if.sv
// Request/response bundle between the control FSM (master) and the divider (slave).
// Request is a one-cycle start pulse; no backpressure, start is dropped while busy.
interface restoring_divider_16bit_if
  import divider_pkg_haleyorr2027::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/restoring_divider_16bit_trial_sub.sv
// One restoring-division step: trial subtract of the divisor from the shifted
// partial remainder, keep the difference if it did not borrow. Combinational.
module div_trial_sub_17bit
  import divider_pkg_haleyorr2027::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   r_shift,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_next,
  output logic             q_bit
);

  logic [WIDTH:0] diff;

  // r_shift < 2*divisor always holds, so the msb of the difference is the borrow.
  always_comb begin
    diff   = r_shift - {1'b0, divisor};
    q_bit  = ~diff[WIDTH];
    r_next = q_bit ? diff : r_shift;
  end

endmodule

// File: rtl/restoring_divider_16bit.sv
// Restoring shift-subtract divider, one quotient bit per clock; SIGNED_DIV_EN adds truncating signed mode.
// Latency: done WIDTH+1 cycles after start is raised (1 for divide-by-zero); start ignored while busy, no queueing.
module restoring_divider_16bit
  import divider_pkg_haleyorr2027::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic                      clk,
  input logic                      reset,
  restoring_divider_16bit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t       state;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvsr;
  logic [CNT_W-1:0] count;

  logic             busy_q;
  logic             done_q;
  logic             dz_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;

  // Between steps R < divisor, so its top bit is always zero and drops out of the shift.
  logic unused_r_msb;
  assign unused_r_msb = r[WIDTH];

  assign r_shift = {r[WIDTH-1:0], q[WIDTH-1]};
  assign q_next  = {q[WIDTH-2:0], q_bit};

  div_trial_sub_17bit #(
    .WIDTH(WIDTH)
  ) u_trial (
    .r_shift(r_shift),
    .divisor(dvsr),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

`ifdef SIGNED_DIV_EN
  logic neg_q;
  logic neg_r;
  logic dividend_neg;
  logic divisor_neg;

  // -32768 maps to magnitude 0x8000, which the unsigned core handles directly.
  always_comb begin
    dividend_neg = bus.signed_op & bus.dividend[WIDTH-1];
    divisor_neg  = bus.signed_op & bus.divisor[WIDTH-1];
    dividend_mag = dividend_neg ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
    divisor_mag  = divisor_neg ? (~bus.divisor + WIDTH'(1)) : bus.divisor;
    q_fin        = neg_q ? (~q_next + WIDTH'(1)) : q_next;
    r_fin        = neg_r ? (~r_next[WIDTH-1:0] + WIDTH'(1)) : r_next[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      neg_q <= dividend_neg ^ divisor_neg;
      neg_r <= dividend_neg;
    end
  end
`else
  logic unused_signed_op;
  assign unused_signed_op = bus.signed_op;

  assign dividend_mag = bus.dividend;
  assign divisor_mag  = bus.divisor;
  assign q_fin        = q_next;
  assign r_fin        = r_next[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      r      <= '0;
      q      <= '0;
      dvsr   <= '0;
      count  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            quot_q <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
            // Zero test uses the raw divisor so signed mode sees the same special case.
            if (bus.divisor == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
              quot_q <= '1;
              rem_q  <= bus.dividend;
              dz_q   <= 1'b1;
            end else begin
              state <= RUN;
              r     <= '0;
              q     <= dividend_mag;
              dvsr  <= divisor_mag;
              count <= CNT_W'(WIDTH);
            end
          end
        end
        RUN: begin
          r     <= r_next;
          q     <= q_next;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state  <= DONE;
            done_q <= 1'b1;
            quot_q <= q_fin;
            rem_q  <= r_fin;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_restoring_divider_16bit.sv
// Directed-vector bench for restoring_divider_16bit with a queue-based scoreboard;
// signed vectors switch expectations on SIGNED_DIV_EN.
module tb_restoring_divider_16bit;

  logic clk;
  logic reset;

  restoring_divider_16bit_if dif ();

  restoring_divider_16bit dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          lat;
    int          t0;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;

  task automatic chk(input string nm, input int tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s tag=%0d: got %h expected %h", nm, tag, got, want);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(posedge clk) begin
    exp_t e;
    edge_cnt++;
    #1;
    if (dif.done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 q=%h r=%h expected no done", dif.quotient, dif.remainder);
      end else begin
        e = sb.pop_front();
        chk("quotient", e.tag, 32'(dif.quotient), 32'(e.q));
        chk("remainder", e.tag, 32'(dif.remainder), 32'(e.r));
        chk("div_by_zero", e.tag, 32'(dif.div_by_zero), 32'(e.dz));
        chk("latency", e.tag, 32'(edge_cnt - e.t0), 32'(e.lat));
      end
    end
  end

  task automatic push_exp(input logic [15:0] eq, input logic [15:0] er, input logic ez,
                          input int lat, input int tag);
    exp_t e;
    e.q   = eq;
    e.r   = er;
    e.dz  = ez;
    e.lat = lat;
    e.t0  = edge_cnt;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain(input int tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || dif.busy !== 1'b0) && n < 60) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("drain_timeout", tag, 32'(n >= 60), 32'd0);
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [15:0] eq, input logic [15:0] er, input logic ez,
                       input int lat, input int tag);
    @(posedge clk);
    #2;
    dif.dividend  = a;
    dif.divisor   = b;
    dif.signed_op = s;
    dif.start     = 1'b1;
    push_exp(eq, er, ez, lat, tag);
    @(posedge clk);
    #2;
    dif.start    = 1'b0;
    dif.dividend = 16'h5A5A;
    dif.divisor  = 16'h0003;
    drain(tag);
  endtask

  task automatic chk_idle_outputs(input int tag);
    chk("busy_idle", tag, 32'(dif.busy), 32'd0);
    chk("done_idle", tag, 32'(dif.done), 32'd0);
    chk("quotient_idle", tag, 32'(dif.quotient), 32'd0);
    chk("remainder_idle", tag, 32'(dif.remainder), 32'd0);
    chk("div_by_zero_idle", tag, 32'(dif.div_by_zero), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    dif.start     = 1'b0;
    dif.signed_op = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    chk_idle_outputs(0);

    // 100/7 with busy profile and two starts that must be ignored.
    @(posedge clk);
    #2;
    dif.dividend  = 16'd100;
    dif.divisor   = 16'd7;
    dif.signed_op = 1'b0;
    dif.start     = 1'b1;
    push_exp(16'd14, 16'd2, 1'b0, 17, 1);
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk);
      #2;
      dif.start = (c == 2 || c == 16);
      if (c == 2) begin
        dif.dividend = 16'd50;
        dif.divisor  = 16'd5;
      end
      chk("busy_profile", c, 32'(dif.busy), 32'(c <= 17));
    end
    dif.start = 1'b0;
    drain(1);

    issue(16'd50, 16'd5, 1'b0, 16'd10, 16'd0, 1'b0, 17, 2);
    issue(16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 17, 3);
    issue(16'd5, 16'd10, 1'b0, 16'd0, 16'd5, 1'b0, 17, 4);
    issue(16'h1234, 16'h1234, 1'b0, 16'd1, 16'd0, 1'b0, 17, 5);
    issue(16'h00AB, 16'h0000, 1'b0, 16'hFFFF, 16'h00AB, 1'b1, 1, 6);

    // Reset during the 8th RUN cycle: no done, outputs cleared.
    issue(16'd50, 16'd5, 1'b0, 16'd10, 16'd0, 1'b0, 17, 7);
    @(posedge clk);
    #2;
    dif.dividend = 16'd100;
    dif.divisor  = 16'd7;
    dif.start    = 1'b1;
    @(posedge clk);
    #2;
    dif.start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    chk_idle_outputs(8);
    repeat (20) @(posedge clk);
    #2;
    issue(16'd9, 16'd4, 1'b0, 16'd2, 16'd1, 1'b0, 17, 9);

    issue(16'hFFF9, 16'h0002, 1'b0, 16'h7FFC, 16'h0001, 1'b0, 17, 10);
`ifdef SIGNED_DIV_EN
    issue(16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 17, 11);
    issue(16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 17, 12);
    issue(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 17, 13);
`else
    issue(16'hFFF9, 16'h0002, 1'b1, 16'h7FFC, 16'h0001, 1'b0, 17, 11);
    issue(16'h0007, 16'hFFFE, 1'b1, 16'h0000, 16'h0007, 1'b0, 17, 12);
    issue(16'h8000, 16'hFFFF, 1'b1, 16'h0000, 16'h8000, 1'b0, 17, 13);
`endif
    issue(16'hFFFB, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFB, 1'b1, 1, 14);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_empty", 99, 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
